// File: rtl/conv_out_streamer.sv
// Snapshots a full H x W signed partial-sum frame and drains it row-major as a valid/ready stream.
// Optional build macro OUT_RELU_EN clamps negative elements to zero at the output.
module conv_out_streamer #(
  parameter int H          = 12,
  parameter int W          = 11,
  parameter int DATA_WIDTH = 24
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  input  logic [H-1:0][W-1:0][DATA_WIDTH-1:0]     in_data,
  output logic                                    busy,
  output logic                                    drop,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [DATA_WIDTH-1:0]                   m_data,
  output logic                                    m_last
);

  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                                state_q, state_d;
  logic [RW-1:0]                         row_q, row_d;
  logic [CW-1:0]                         col_q, col_d;
  logic                                  drop_q, drop_d;
  logic                                  capture_s;
  logic                                  xfer_s;
  logic                                  at_end_s;
  logic [H-1:0][W-1:0][DATA_WIDTH-1:0]   snap_q;
  logic [DATA_WIDTH-1:0]                 elem_s;
  logic [DATA_WIDTH-1:0]                 out_s;

  assign xfer_s   = (state_q == STREAM) && m_ready;
  assign at_end_s = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Next-state, counter advance, capture and drop decisions
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    drop_d    = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture_s = 1'b1;
          row_d     = {RW{1'b0}};
          col_d     = {CW{1'b0}};
          state_d   = STREAM;
        end else begin
          state_d   = IDLE;
        end
      end
      STREAM: begin
        if (xfer_s && at_end_s) begin
          row_d = {RW{1'b0}};
          col_d = {CW{1'b0}};
          // A frame arriving with the final beat is chained without a bubble
          if (in_valid) begin
            capture_s = 1'b1;
            state_d   = STREAM;
          end else begin
            state_d   = IDLE;
          end
        end else if (xfer_s) begin
          if (col_q == COL_LAST) begin
            col_d = {CW{1'b0}};
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          drop_d = in_valid;
        end else begin
          drop_d = in_valid;
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = {RW{1'b0}};
        col_d   = {CW{1'b0}};
      end
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= {RW{1'b0}};
      col_q   <= {CW{1'b0}};
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drop_q  <= drop_d;
    end
  end

  // Frame snapshot; contents are don't-care until the first capture
  always_ff @(posedge clk) begin
    if (capture_s) begin
      snap_q <= in_data;
    end else begin
      snap_q <= snap_q;
    end
  end

  assign elem_s = snap_q[row_q][col_q];

`ifdef OUT_RELU_EN
  assign out_s = elem_s[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : elem_s;
`else
  assign out_s = elem_s;
`endif

  assign m_valid = (state_q == STREAM);
  assign busy    = m_valid;
  assign drop    = drop_q;
  assign m_data  = m_valid ? out_s : {DATA_WIDTH{1'b0}};
  assign m_last  = m_valid && at_end_s;

endmodule

// File: tb/tb_conv_out_streamer.sv
// Self-checking bench for conv_out_streamer: directed vector table, corner sequences and a
// randomized run against a queue-based frame model.
module tb_conv_out_streamer;

  localparam int H  = 12;
  localparam int W  = 11;
  localparam int DW = 24;
  localparam int N  = H * W;

  logic                          clk;
  logic                          rst_n;
  logic                          in_valid;
  logic [H-1:0][W-1:0][DW-1:0]   in_data;
  logic                          busy;
  logic                          drop;
  logic                          m_valid;
  logic                          m_ready;
  logic [DW-1:0]                 m_data;
  logic                          m_last;

  conv_out_streamer #(.H(H), .W(W), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .busy     (busy),
    .drop     (drop),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [H-1:0][W-1:0][DW-1:0] frame;
  logic [DW-1:0] exp_q[$];
  logic          exp_drop;
  int            xfer_cnt;
  int            last_cnt;

  typedef struct {
    logic          iv;
    logic          rdy;
    logic          e_valid;
    logic          e_drop;
    logic [DW-1:0] e_data;
    logic          e_last;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef OUT_RELU_EN
    return x[DW-1] ? 24'd0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic          ev;
    logic [DW-1:0] ed;
    ev = (exp_q.size() > 0);
    ed = ev ? relu(exp_q[0]) : 24'd0;
    chk("m_valid", {31'd0, m_valid}, {31'd0, ev});
    chk("busy",    {31'd0, busy},    {31'd0, ev});
    chk("m_data",  {8'd0, m_data},   {8'd0, ed});
    chk("m_last",  {31'd0, m_last},  {31'd0, (exp_q.size() == 1)});
    chk("drop",    {31'd0, drop},    {31'd0, exp_drop});
  endtask

  // One clock: drive inputs, advance the model over the edge, compare outputs after it
  task automatic cycle(input logic iv, input logic rdy);
    logic          active;
    logic          xfer;
    logic [DW-1:0] tmp;
    in_valid = iv;
    m_ready  = rdy;
    in_data  = frame;
    if (m_valid && rdy) xfer_cnt++;
    if (m_valid && m_last && rdy) last_cnt++;
    active   = (exp_q.size() > 0);
    xfer     = active && rdy;
    exp_drop = 1'b0;
    if (xfer) tmp = exp_q.pop_front();
    if (iv) begin
      if (!active || (xfer && exp_q.size() == 0)) begin
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++)
            exp_q.push_back(frame[r][c]);
      end else begin
        exp_drop = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = DW'(r * W + c);
  endtask

  task automatic set_const(input logic [DW-1:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = v;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * N && exp_q.size() > 0; i++) cycle(1'b0, 1'b1);
    chk("drain_done", {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    exp_drop = 1'b0;
    xfer_cnt = 0;
    last_cnt = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    m_ready  = 1'b0;
    set_ramp();
    in_data  = frame;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_drop",    {31'd0, drop},    32'd0);
    chk("rst_m_last",  {31'd0, m_last},  32'd0);
    chk("rst_m_data",  {8'd0, m_data},   32'd0);
    rst_n = 1'b1;

    // Directed table on the ramp frame: accept, stall, advance, reject while busy
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'd1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 24'd1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'd2, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'd3, 1'b0};
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].iv, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_drop", i),  {31'd0, drop},    {31'd0, vecs[i].e_drop});
      chk($sformatf("vec%0d_data", i),  {8'd0, m_data},   {8'd0, vecs[i].e_data});
      chk($sformatf("vec%0d_last", i),  {31'd0, m_last},  {31'd0, vecs[i].e_last});
    end
    drain();

    // Full-rate drain: 132 beats, one last
    xfer_cnt = 0; last_cnt = 0;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b1);
    chk("t1_xfers", xfer_cnt, N);
    chk("t1_lasts", last_cnt, 32'd1);
    chk("t1_idle",  {31'd0, m_valid}, 32'd0);

    // Alternating ready
    xfer_cnt = 0; last_cnt = 0;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 4 * N && exp_q.size() > 0; i++) cycle(1'b0, (i % 2) == 0);
    chk("t2_xfers", xfer_cnt, N);
    chk("t2_lasts", last_cnt, 32'd1);

    // Rejected frame at beat 40
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1);
    chk("t3_beat40", {8'd0, m_data}, 32'd40);
    set_const(24'd99);
    cycle(1'b1, 1'b1);
    chk("t3_drop", {31'd0, drop}, 32'd1);
    chk("t3_data", {8'd0, m_data}, 32'd41);
    cycle(1'b0, 1'b1);
    chk("t3_drop_clear", {31'd0, drop}, 32'd0);
    drain();

    // New frame coincident with the final transfer
    set_ramp();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 4 * N && exp_q.size() > 1; i++) cycle(1'b0, 1'b1);
    chk("t4_at_last", {31'd0, m_last}, 32'd1);
    set_const(24'd7);
    cycle(1'b1, 1'b1);
    chk("t4_valid", {31'd0, m_valid}, 32'd1);
    chk("t4_data",  {8'd0, m_data},   32'd7);
    chk("t4_drop",  {31'd0, drop},    32'd0);
    chk("t4_last",  {31'd0, m_last},  32'd0);
    drain();

    // Negative elements
    set_const(24'hFFFFFB);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin
`ifdef OUT_RELU_EN
      chk("t5_neg", {8'd0, m_data}, 32'd0);
`else
      chk("t5_neg", {8'd0, m_data}, 32'h00FFFFFB);
`endif
      cycle(1'b0, 1'b1);
    end
    chk("t5_idle", {31'd0, m_valid}, 32'd0);

    // Reset mid-frame at beat 60
    set_ramp();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_busy",    {31'd0, busy},    32'd0);
    chk("t6_m_last",  {31'd0, m_last},  32'd0);
    chk("t6_drop",    {31'd0, drop},    32'd0);
    chk("t6_m_data",  {8'd0, m_data},   32'd0);
    exp_q.delete();
    exp_drop = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          frame[r][c] = DW'($urandom);
      cycle(($urandom % 25) == 0, ($urandom % 4) != 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
